// File: rtl/regfile_pkg.sv
// Shared configuration for the register file: default geometry and the data word type.
package regfile_pkg;

  localparam int unsigned RF_ADDR_W = 6;
  localparam int unsigned RF_DEPTH  = 1 << RF_ADDR_W;
  localparam int unsigned RF_WIDTH  = 16;

  typedef logic signed [RF_WIDTH-1:0] rf_word_t;

endpackage

// File: rtl/regfile.sv
// Flop-based register file: one write port and one registered read port (1-cycle latency).
// Asynchronous active-low reset clears every entry and the read register.
module regfile
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH  = RF_DEPTH,
  parameter int unsigned WIDTH  = RF_WIDTH,
  parameter int unsigned ADDR_W = RF_ADDR_W
) (
  input  logic                    clk2,
  input  logic                    rstn,
  input  logic                    wen,
  input  logic [ADDR_W-1:0]       waddr,
  input  logic signed [WIDTH-1:0] din,
  input  logic                    ren,
  input  logic [ADDR_W-1:0]       raddr,
  output logic signed [WIDTH-1:0] dout
);

  logic signed [WIDTH-1:0] r_mem [DEPTH];
  logic signed [WIDTH-1:0] r_dout;
  logic signed [WIDTH-1:0] w_rdata;
  logic [DEPTH-1:0]        w_we;

  always_comb begin
    w_we = '0;
    if (wen) begin
      w_we[waddr] = 1'b1;
    end
  end

  // Each entry is its own flop bank so reset can clear all of them asynchronously.
  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    always_ff @(posedge clk2 or negedge rstn) begin
      if (!rstn) begin
        r_mem[g] <= '0;
      end else if (w_we[g]) begin
        r_mem[g] <= din;
      end
    end
  end

  // Read samples the pre-edge array, so a same-address write returns the old word.
  assign w_rdata = r_mem[raddr];

  always_ff @(posedge clk2 or negedge rstn) begin
    if (!rstn) begin
      r_dout <= '0;
    end else if (ren) begin
      r_dout <= w_rdata;
    end
  end

  assign dout = r_dout;

endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: vector table plus hand-written reset, fill, collision and hold cases.
module tb_regfile;

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 16;
  localparam int unsigned N  = 64;

  logic                 clk2;
  logic                 rstn;
  logic                 wen;
  logic [AW-1:0]        waddr;
  logic signed [DW-1:0] din;
  logic                 ren;
  logic [AW-1:0]        raddr;
  logic signed [DW-1:0] dout;

  int n_checks;
  int n_errors;

  typedef struct {
    logic          wen;
    logic [AW-1:0] waddr;
    logic [DW-1:0] din;
    logic          ren;
    logic [AW-1:0] raddr;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t          vecs[8];
  logic [DW-1:0] shadow[N];

  regfile #(
    .DEPTH (N),
    .WIDTH (DW),
    .ADDR_W(AW)
  ) u_dut (
    .clk2 (clk2),
    .rstn (rstn),
    .wen  (wen),
    .waddr(waddr),
    .din  (din),
    .ren  (ren),
    .raddr(raddr),
    .dout (dout)
  );

  initial clk2 = 1'b0;
  always #5 clk2 = ~clk2;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  // Advance one rising edge and settle just past it.
  task automatic step();
    @(posedge clk2);
    #1;
  endtask

  task automatic drive(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] d,
                       input logic r, input logic [AW-1:0] ra);
    wen   = w;
    waddr = wa;
    din   = d;
    ren   = r;
    raddr = ra;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    drive(1'b0, '0, '0, 1'b0, '0);

    vecs[0] = '{1'b1, 6'd7,  16'h00A5, 1'b0, 6'd0, 16'h0000};
    vecs[1] = '{1'b1, 6'd8,  16'hFF00, 1'b1, 6'd7, 16'h00A5};
    vecs[2] = '{1'b0, 6'd0,  16'h0000, 1'b1, 6'd8, 16'hFF00};
    vecs[3] = '{1'b0, 6'd7,  16'h1234, 1'b1, 6'd7, 16'h00A5};
    vecs[4] = '{1'b0, 6'd0,  16'h0000, 1'b0, 6'd8, 16'h00A5};
    vecs[5] = '{1'b0, 6'd0,  16'h0000, 1'b1, 6'd9, 16'h0000};
    vecs[6] = '{1'b1, 6'd9,  16'h8001, 1'b1, 6'd9, 16'h0000};
    vecs[7] = '{1'b0, 6'd0,  16'h0000, 1'b1, 6'd9, 16'h8001};

    // Reset held for 3 cycles, with enables asserted to show they are ignored.
    rstn = 1'b0;
    drive(1'b1, 6'd5, 16'h5555, 1'b1, 6'd5);
    #1;
    check("reset_dout_immediate", dout, 16'h0000);
    repeat (3) step();
    check("reset_dout_held", dout, 16'h0000);
    drive(1'b0, '0, '0, 1'b0, '0);
    #2;
    rstn = 1'b1;
    drive(1'b0, '0, '0, 1'b1, 6'd0);
    step();
    check("reset_read_0", dout, 16'h0000);
    raddr = 6'd31;
    step();
    check("reset_read_31", dout, 16'h0000);
    raddr = 6'd63;
    step();
    check("reset_read_63", dout, 16'h0000);
    raddr = 6'd5;
    step();
    check("reset_ignored_write", dout, 16'h0000);

    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].wen, vecs[i].waddr, vecs[i].din, vecs[i].ren, vecs[i].raddr);
      step();
      check($sformatf("vec%0d", i), dout, vecs[i].exp);
    end

    // Fill every address with random data, then sweep reads one per cycle.
    for (int i = 0; i < int'(N); i++) begin
      shadow[i] = 16'($urandom);
      drive(1'b1, AW'(i), shadow[i], 1'b0, '0);
      step();
    end
    for (int i = 0; i < int'(N); i++) begin
      drive(1'b0, '0, '0, 1'b1, AW'(i));
      step();
      check($sformatf("sweep_%0d", i), dout, shadow[i]);
    end

    // Same-address collision returns the old word, new word visible next read.
    drive(1'b1, 6'd10, 16'h0001, 1'b0, '0);
    step();
    drive(1'b1, 6'd10, 16'h1234, 1'b1, 6'd10);
    step();
    check("collision_old", dout, 16'h0001);
    drive(1'b0, '0, '0, 1'b1, 6'd10);
    step();
    check("collision_new", dout, 16'h1234);

    // Read hold while address changes and the held address is rewritten.
    drive(1'b1, 6'd5, 16'h7FFF, 1'b0, '0);
    step();
    drive(1'b0, '0, '0, 1'b1, 6'd5);
    step();
    check("hold_read", dout, 16'h7FFF);
    drive(1'b1, 6'd5, 16'h8000, 1'b0, 6'd6);
    step();
    check("hold_1", dout, 16'h7FFF);
    drive(1'b0, '0, '0, 1'b0, 6'd0);
    step();
    check("hold_2", dout, 16'h7FFF);
    drive(1'b0, '0, '0, 1'b1, 6'd5);
    step();
    check("hold_after_write", dout, 16'h8000);

    // Reset asserted between edges mid-operation.
    drive(1'b1, 6'd3, 16'hBEEF, 1'b0, '0);
    step();
    drive(1'b0, '0, '0, 1'b1, 6'd3);
    step();
    check("midrst_pre_read", dout, 16'hBEEF);
    drive(1'b1, 6'd3, 16'h1111, 1'b1, 6'd10);
    #3;
    rstn = 1'b0;
    #1;
    check("midrst_dout_immediate", dout, 16'h0000);
    step();
    check("midrst_dout_held", dout, 16'h0000);
    #2;
    rstn = 1'b1;
    // First edge after release performs a write and a read together.
    drive(1'b1, 6'd20, 16'h2222, 1'b1, 6'd3);
    step();
    check("midrst_read_3", dout, 16'h0000);
    drive(1'b0, '0, '0, 1'b1, 6'd10);
    step();
    check("midrst_read_10", dout, 16'h0000);
    raddr = 6'd20;
    step();
    check("post_rst_first_write", dout, 16'h2222);

    // Signed extremes at the address boundaries.
    drive(1'b1, 6'd0, 16'h8000, 1'b0, '0);
    step();
    drive(1'b1, 6'd63, 16'h7FFF, 1'b1, 6'd0);
    step();
    check("signed_min", dout, 16'h8000);
    n_checks++;
    if (int'(dout) != -32768) begin
      n_errors++;
      $display("FAIL signed_min_value: got %0d expected -32768", dout);
    end
    drive(1'b0, '0, '0, 1'b1, 6'd63);
    step();
    check("signed_max", dout, 16'h7FFF);
    n_checks++;
    if (int'(dout) != 32767) begin
      n_errors++;
      $display("FAIL signed_max_value: got %0d expected 32767", dout);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 The block SHALL have parameter DEPTH, default 64, number of storage entries.
REQ-002 The block SHALL have parameter WIDTH, default 16, data bits per entry, signed two's complement.
REQ-003 The block SHALL have parameter ADDR_W, default 6, address bits, with DEPTH = 2**ADDR_W.
REQ-004 The block SHALL have port clk2, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rstn, input, 1 bit, asynchronous active-low reset.
REQ-006 The block SHALL have port wen, input, 1 bit, write enable.
REQ-007 The block SHALL have port waddr, input, ADDR_W bits, write address.
REQ-008 The block SHALL have port din, input, WIDTH bits signed, write data.
REQ-009 The block SHALL have port ren, input, 1 bit, read enable.
REQ-010 The block SHALL have port raddr, input, ADDR_W bits, read address.
REQ-011 The block SHALL have port dout, output, WIDTH bits signed, registered read data.

Function
REQ-012 Write: on a rising clk2 edge with rstn=1 and wen=1, mem[waddr] SHALL take din; with wen=0 no entry changes.
REQ-013 Read: on a rising clk2 edge with rstn=1 and ren=1, dout SHALL take mem[raddr], giving exactly 1 cycle of latency from raddr to dout.
REQ-014 Read hold: with ren=0, dout SHALL hold its previous value.
REQ-015 Same-address collision: with wen=1, ren=1 and waddr=raddr on one edge, dout SHALL return the old (pre-write) contents, and the new value SHALL be readable from the next read edge onward.
REQ-016 Different-address simultaneous read and write SHALL both complete in the same cycle, independently.
REQ-017 Addresses SHALL cover 0..DEPTH-1 fully, with no out-of-range case; back-to-back reads at incrementing addresses SHALL deliver one word per cycle.
REQ-018 Data SHALL be stored and returned bit-exact, with no sign extension, truncation or arithmetic.

Reset
REQ-019 While rstn=0, dout SHALL be 0 immediately, independent of clk2.
REQ-020 While rstn=0, all DEPTH entries SHALL be cleared to 0, and wen and ren SHALL be ignored.
REQ-021 Reset asserted mid-operation SHALL abort any pending write and read in that cycle.
REQ-022 After rstn deasserts, the first rising edge SHALL perform normal writes and reads.

Structure
REQ-023 The DEPTH, WIDTH and ADDR_W defaults SHALL reside in a shared package regfile_pkg, used as parameter defaults.
REQ-024 The block SHALL be a single flat module (flop-based array plus output register), with no sub-module.

Verification
REQ-025 Reset: hold rstn=0 for 3 cycles, then release -> dout=0, and reads of addresses 0, 31 and 63 return 0.
REQ-026 Fill and readback: write 64 random values to addresses 0..63 over 64 cycles, then ren=1 and sweep raddr 0..63 -> each dout equals the shadow model one cycle after its address, with zero mismatches.
REQ-027 Collision: mem[10]=0x0001; one edge with wen=1, waddr=10, din=0x1234, ren=1, raddr=10 -> dout=0x0001; the next read of 10 -> dout=0x1234.
REQ-028 Hold: read address 5 (value 0x7FFF), then ren=0 while changing raddr and writing address 5 with 0x8000 -> dout stays 0x7FFF.
REQ-029 Mid-operation reset: write 0xBEEF to address 3 and read it, pull rstn low between edges -> dout=0 at once, and after release a read of address 3 returns 0.
REQ-030 Signed extremes: write 0x8000 to address 0 and 0x7FFF to address 63, then read both -> exact values returned (-32768 and 32767).
